conv_1x1_accum_13: RTL and testbench



---
 rtl/conv_1x1_accum_13_pkg.sv | 16 +
 rtl/conv_1x1_accum_13_fp_add.sv | 126 ++++++++++++
 rtl/conv_1x1_accum_13.sv | 121 ++++++++++++
 tb/tb_conv_1x1_accum_13.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_1x1_accum_13_pkg.sv
// Shared constants for the 1x1 convolution channel accumulator.
//   FP_ZERO  : +0.0 single precision, operand B for the first input channel
//   FP_QNAN  : canonical quiet NaN returned for invalid additions
//   ADD_LAT  : registered latency of the floating-point adder
//   cnt_width: counter width for a modulus n (at least one bit)
package conv_1x1_accum_13_pkg;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam int unsigned ADD_LAT = 1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_1x1_accum_13_fp_add.sv
// Single-precision floating-point adder, one registered cycle.
// Round-to-nearest-even, denormal inputs/outputs flushed to zero, +0 + -0 = +0.
//   clk, reset  : clock, synchronous active-high reset
//   valid_in    : in_a/in_b carry operands this cycle
//   in_a, in_b  : IEEE-754 single operands
//   out         : registered sum
//   valid_out   : out valid, one cycle after valid_in
module conv_1x1_accum_13_fp_add
    import conv_1x1_accum_13_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  valid_out
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("conv_1x1_accum_13_fp_add supports single precision only");
    end

    logic        a_zero, b_zero, a_spec, b_spec, a_nan, b_nan;
    logic        swap, big_s, small_s, diff_zero, rup;
    logic [7:0]  big_e, small_e, d;
    logic [23:0] big_m, small_m;
    logic [4:0]  dsh, lz;
    logic [53:0] shv;
    logic [26:0] big_al, small_al, diff, norm;
    logic [27:0] sum;
    logic [9:0]  e, e_f;
    logic [24:0] rm;
    logic [31:0] res;

    // Combinational add: align, add/subtract, normalise, round.
    always_comb begin
        res       = FP_ZERO;
        lz        = '0;
        norm      = '0;
        e         = '0;
        sum       = '0;
        diff      = '0;
        diff_zero = 1'b0;

        a_zero = (in_a[30:23] == 8'h00);
        b_zero = (in_b[30:23] == 8'h00);
        a_spec = (in_a[30:23] == 8'hFF);
        b_spec = (in_b[30:23] == 8'hFF);
        a_nan  = a_spec && (in_a[22:0] != 23'h0);
        b_nan  = b_spec && (in_b[22:0] != 23'h0);

        swap    = (in_b[30:0] > in_a[30:0]);
        big_s   = swap ? in_b[31]    : in_a[31];
        small_s = swap ? in_a[31]    : in_b[31];
        big_e   = swap ? in_b[30:23] : in_a[30:23];
        small_e = swap ? in_a[30:23] : in_b[30:23];
        big_m   = {1'b1, swap ? in_b[22:0] : in_a[22:0]};
        small_m = {1'b1, swap ? in_a[22:0] : in_b[22:0]};

        // Alignment shift; bits shifted past the guard/round positions fold into sticky.
        d        = big_e - small_e;
        dsh      = (d > 8'd27) ? 5'd27 : d[4:0];
        shv      = {small_m, 3'b000, 27'h0} >> dsh;
        small_al = shv[53:27] | {26'h0, |shv[26:0]};
        big_al   = {big_m, 3'b000};

        if (big_s == small_s) begin
            sum = {1'b0, big_al} + {1'b0, small_al};
            if (sum[27]) begin
                norm = {sum[27:2], sum[1] | sum[0]};
                e    = {2'b00, big_e} + 10'd1;
            end else begin
                norm = sum[26:0];
                e    = {2'b00, big_e};
            end
        end else begin
            diff      = big_al - small_al;
            diff_zero = (diff == 27'h0);
            for (int i = 0; i < 27; i++) begin
                if (diff[i]) lz = 5'(26 - i);
            end
            norm = diff << lz;
            e    = {2'b00, big_e} - {5'b00000, lz};
        end

        rup = norm[2] & (norm[1] | norm[0] | norm[3]);
        rm  = {1'b0, norm[26:3]} + 25'(rup);
        e_f = e + {9'h0, rm[24]};

        if (a_spec || b_spec) begin
            if (a_nan || b_nan || (a_spec && b_spec && (in_a[31] != in_b[31])))
                res = FP_QNAN;
            else
                res = a_spec ? in_a : in_b;
        end else if (a_zero && b_zero) begin
            res = {in_a[31] & in_b[31], 31'h0};
        end else if (a_zero) begin
            res = in_b;
        end else if (b_zero) begin
            res = in_a;
        end else if (diff_zero) begin
            res = FP_ZERO;
        end else if (e_f[9] || (e_f == 10'h0)) begin
            res = {big_s, 31'h0};
        end else if (e_f >= 10'd255) begin
            res = {big_s, 8'hFF, 23'h0};
        end else begin
            res = {big_s, e_f[7:0], rm[24] ? rm[23:1] : rm[22:0]};
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) out <= res;
        end
    end

endmodule

// File: rtl/conv_1x1_accum_13.sv
// Channel accumulator behind the 1x1 convolution multiplier: sums each pixel's
// products over CHANNEL_NUM_IN input channels using an IMAGE_SIZE-deep buffer.
//   clk, reset : clock, synchronous active-high reset
//   valid_in   : pxl_in carries a product (channel-major, raster order)
//   pxl_in     : product word
//   pxl_out    : accumulated pixel sum
//   valid_out  : single-cycle pulse per finished pixel, 2 cycles after last product
module conv_1x1_accum_13
    import conv_1x1_accum_13_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned IMAGE_WIDTH     = 64,
    parameter int unsigned IMAGE_HEIGHT    = 64,
    parameter int unsigned CHANNEL_NUM_IN  = 256,
    parameter int unsigned CHANNEL_NUM_OUT = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out
);

    localparam int unsigned IMAGE_SIZE    = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned CNT_WIDTH_PIX = cnt_width(IMAGE_SIZE);
    localparam int unsigned CNT_WIDTH_CH  = cnt_width(CHANNEL_NUM_IN);
    localparam int unsigned CNT_WIDTH_OCH = cnt_width(CHANNEL_NUM_OUT);

    // Write-back lands two cycles after the read; a shorter pixel loop would read stale sums.
    if (IMAGE_SIZE < 3) begin : g_size_check
        $error("conv_1x1_accum_13 requires IMAGE_SIZE >= 3");
    end

    logic [CNT_WIDTH_PIX-1:0] pix_cnt;
    logic [CNT_WIDTH_CH-1:0]  ch_cnt;
    logic [CNT_WIDTH_OCH-1:0] och_cnt;

    logic                     s0_valid, s0_first, s0_last;
    logic [DATA_WIDTH-1:0]    s0_data;
    logic [CNT_WIDTH_PIX-1:0] s0_addr;
    logic                     s1_last;
    logic [CNT_WIDTH_PIX-1:0] s1_addr;

    logic [DATA_WIDTH-1:0]    mem [IMAGE_SIZE];
    logic [DATA_WIDTH-1:0]    rd_data;
    logic [DATA_WIDTH-1:0]    op_b_c;
    logic [DATA_WIDTH-1:0]    add_out;
    logic                     add_valid;

    // Position counters and the stage-0/stage-1 control pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt   <= '0;
            ch_cnt    <= '0;
            och_cnt   <= '0;
            s0_valid  <= 1'b0;
            s0_first  <= 1'b0;
            s0_last   <= 1'b0;
            s0_data   <= '0;
            s0_addr   <= '0;
            s1_last   <= 1'b0;
            s1_addr   <= '0;
            pxl_out   <= '0;
            valid_out <= 1'b0;
        end else begin
            s0_valid <= valid_in;
            if (valid_in) begin
                s0_data  <= pxl_in;
                s0_addr  <= pix_cnt;
                s0_first <= (ch_cnt == '0);
                s0_last  <= (ch_cnt == CNT_WIDTH_CH'(CHANNEL_NUM_IN - 1));
                if (pix_cnt == CNT_WIDTH_PIX'(IMAGE_SIZE - 1)) begin
                    pix_cnt <= '0;
                    if (ch_cnt == CNT_WIDTH_CH'(CHANNEL_NUM_IN - 1)) begin
                        ch_cnt <= '0;
                        if (och_cnt == CNT_WIDTH_OCH'(CHANNEL_NUM_OUT - 1))
                            och_cnt <= '0;
                        else
                            och_cnt <= och_cnt + 1'b1;
                    end else begin
                        ch_cnt <= ch_cnt + 1'b1;
                    end
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
            if (s0_valid) begin
                s1_addr <= s0_addr;
                s1_last <= s0_last;
            end
            valid_out <= add_valid && s1_last;
            if (add_valid && s1_last) pxl_out <= add_out;
        end
    end

    // Partial-sum buffer: synchronous read at stage 0, write-back at stage 2.
    always_ff @(posedge clk) begin
        if (valid_in) rd_data <= mem[pix_cnt];
        if (add_valid && !s1_last) mem[s1_addr] <= add_out;
    end

    // First channel adds to zero, discarding whatever the previous output channel left.
    assign op_b_c = s0_first ? DATA_WIDTH'(FP_ZERO) : rd_data;

    conv_1x1_accum_13_fp_add #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fp_add (
        .clk      (clk),
        .reset    (reset),
        .valid_in (s0_valid),
        .in_a     (s0_data),
        .in_b     (op_b_c),
        .out      (add_out),
        .valid_out(add_valid)
    );

    ochcnt_range: assert property (@(posedge clk) disable iff (reset)
        och_cnt <= CNT_WIDTH_OCH'(CHANNEL_NUM_OUT - 1));

endmodule

// File: tb/tb_conv_1x1_accum_13.sv
module tb_conv_1x1_accum_13;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] pxl_in;
    logic [31:0] pxl_out;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vin;
        logic [31:0] din;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [64];
    int   n;

    always #5 clk = ~clk;

    conv_1x1_accum_13 #(
        .DATA_WIDTH     (32),
        .IMAGE_WIDTH    (2),
        .IMAGE_HEIGHT   (2),
        .CHANNEL_NUM_IN (3),
        .CHANNEL_NUM_OUT(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .pxl_in   (pxl_in),
        .pxl_out  (pxl_out),
        .valid_out(valid_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tbl_clear();
        n = 0;
    endtask

    task automatic tbl_add(input logic v, input logic [31:0] d);
        tbl[n] = '{vin: v, din: d, ev: 1'b0, ed: 32'h0};
        n++;
    endtask

    task automatic tbl_pad(input int k);
        for (int i = 0; i < k; i++) tbl_add(1'b0, 32'h0);
    endtask

    task automatic tbl_exp(input int idx, input logic [31:0] d);
        tbl[idx].ev = 1'b1;
        tbl[idx].ed = d;
    endtask

    // One channel of four pixels, all carrying d; alt inserts a bubble after each.
    task automatic tbl_ch(input logic [31:0] d, input logic alt);
        for (int p = 0; p < 4; p++) begin
            tbl_add(1'b1, d);
            if (alt) tbl_add(1'b0, 32'h0);
        end
    endtask

    task automatic run_table(input string name);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            valid_in = tbl[k].vin;
            pxl_in   = tbl[k].din;
            @(posedge clk);
            #1;
            if (tbl[k].ev) begin
                check({name, "_valid"}, 32'(valid_out), 32'h1);
                check({name, "_data"}, pxl_out, tbl[k].ed);
            end else begin
                check({name, "_idle"}, 32'(valid_out), 32'h0);
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        pxl_in   = 32'h0;
    endtask

    task automatic build_t1();
        tbl_clear();
        tbl_ch(32'h3F800000, 1'b0);
        tbl_ch(32'h40000000, 1'b0);
        tbl_ch(32'h40400000, 1'b0);
        tbl_pad(3);
        for (int i = 10; i < 14; i++) tbl_exp(i, 32'h40C00000);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        pxl_in   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid_out), 32'h0);
        check("reset_data", pxl_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 1: back-to-back, 1+2+3 = 6 per pixel
        build_t1();
        run_table("t1");

        // 2: distinct per-pixel values, sums 3,6,9,12
        tbl_clear();
        for (int c = 0; c < 3; c++) begin
            tbl_add(1'b1, 32'h3F800000);
            tbl_add(1'b1, 32'h40000000);
            tbl_add(1'b1, 32'h40400000);
            tbl_add(1'b1, 32'h40800000);
        end
        tbl_pad(3);
        tbl_exp(10, 32'h40400000);
        tbl_exp(11, 32'h40C00000);
        tbl_exp(12, 32'h41100000);
        tbl_exp(13, 32'h41400000);
        run_table("t2");

        // 3: bubbles between every product
        tbl_clear();
        tbl_ch(32'h3F800000, 1'b1);
        tbl_ch(32'h40000000, 1'b1);
        tbl_ch(32'h40400000, 1'b1);
        tbl_pad(3);
        for (int i = 0; i < 4; i++) tbl_exp(18 + 2 * i, 32'h40C00000);
        run_table("t3");

        // 4: second output channel reuses the buffer without a clear, 0.5*3 = 1.5
        tbl_clear();
        tbl_ch(32'h3F800000, 1'b0);
        tbl_ch(32'h40000000, 1'b0);
        tbl_ch(32'h40400000, 1'b0);
        tbl_ch(32'h3F000000, 1'b0);
        tbl_ch(32'h3F000000, 1'b0);
        tbl_ch(32'h3F000000, 1'b0);
        tbl_pad(3);
        for (int i = 10; i < 14; i++) tbl_exp(i, 32'h40C00000);
        for (int i = 22; i < 26; i++) tbl_exp(i, 32'h3FC00000);
        run_table("t4");

        // 5: abort a frame after 6 products with a one-cycle reset
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            valid_in = 1'b1;
            pxl_in   = 32'h41200000;
            @(posedge clk);
            #1;
            check("t5_pre_idle", 32'(valid_out), 32'h0);
        end
        @(negedge clk);
        valid_in = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_valid", 32'(valid_out), 32'h0);
        check("t5_rst_data", pxl_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t5_post_idle", 32'(valid_out), 32'h0);
        build_t1();
        run_table("t5");

        // 6: pixel 0 gets -1, +1, +2 -> +0 midway, 2.0 final; other pixels stay +0
        tbl_clear();
        tbl_add(1'b1, 32'hBF800000);
        tbl_add(1'b1, 32'h0); tbl_add(1'b1, 32'h0); tbl_add(1'b1, 32'h0);
        tbl_add(1'b1, 32'h3F800000);
        tbl_add(1'b1, 32'h0); tbl_add(1'b1, 32'h0); tbl_add(1'b1, 32'h0);
        tbl_add(1'b1, 32'h40000000);
        tbl_add(1'b1, 32'h0); tbl_add(1'b1, 32'h0); tbl_add(1'b1, 32'h0);
        tbl_pad(3);
        tbl_exp(10, 32'h40000000);
        tbl_exp(11, 32'h00000000);
        tbl_exp(12, 32'h00000000);
        tbl_exp(13, 32'h00000000);
        run_table("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
